// File: rtl/clock_div_mc.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_mc
// Brief    : NCH independent integer clock dividers (N = 0..2^WIDTH-1) with
//            glitch-free runtime reload and a shared phase-align request.
// Revision : 1.0 - initial release
// ============================================================================
module clock_div_mc #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8,
    parameter int DEF_N = 2
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*WIDTH-1:0] div_n,
    input  logic [NCH-1:0]       load,
    input  logic                 sync_all,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       clk_out
);
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [WIDTH-1:0] C_DEF_N = WIDTH'(DEF_N);
    localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_TWO   = WIDTH'(2);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            state_t           state_q, state_d;
            logic [WIDTH-1:0] act_n_q, act_n_d;
            logic [WIDTH-1:0] pend_q, pend_d;
            logic [WIDTH-1:0] cnt_q, cnt_d;
            logic             busy_q, busy_d;
            logic             done_q, done_d;
            logic             tick_q, tick_d;
            logic             hi_q, hi_d;
            logic             hi_neg_q, gate_q, gate_d;
            logic             pend_vld, bnd, stop;
            logic [WIDTH-1:0] new_n, cnt_dec, thr;

            always_comb begin
                state_d  = state_q;
                act_n_d  = act_n_q;
                pend_d   = pend_q;
                cnt_d    = cnt_q;
                busy_d   = busy_q;
                done_d   = done_q;
                tick_d   = 1'b0;
                hi_d     = 1'b0;
                bnd      = 1'b0;
                stop     = 1'b0;
                pend_vld = busy_q & ~done_q;
                new_n    = pend_vld ? pend_q : act_n_q;
                cnt_dec  = cnt_q - C_ONE;
                // High while the count is above ceil(N/2); odd N gets its
                // extra half cycle from the negedge copy of hi_q.
                thr      = (act_n_q >> 1) + {{(WIDTH-1){1'b0}}, act_n_q[0]};

                if (state_q == ST_IDLE) begin
                    if (en[gi]) begin
                        bnd = 1'b1;
                    end else if (pend_vld) begin
                        act_n_d = pend_q;
                        done_d  = 1'b1;
                    end
                end else if (sync_all || (act_n_q <= C_ONE) || (cnt_q <= C_ONE)) begin
                    if (en[gi]) bnd  = 1'b1;
                    else        stop = 1'b1;
                end else begin
                    cnt_d = cnt_dec;
                    hi_d  = (cnt_dec > thr);
                end

                if (bnd) begin
                    state_d = ST_RUN;
                    act_n_d = new_n;
                    cnt_d   = new_n;
                    tick_d  = 1'b1;
                    hi_d    = (new_n >= C_TWO);
                    if (pend_vld) done_d = 1'b1;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                    act_n_d = new_n;
                    cnt_d   = '0;
                    if (pend_vld) done_d = 1'b1;
                end

                if (busy_q && done_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b0;
                end else if (load[gi] && !busy_q) begin
                    pend_d = div_n[gi*WIDTH +: WIDTH];
                    busy_d = 1'b1;
                    done_d = 1'b0;
                end

                // Bypass gate follows the state the next posedge will enter,
                // so it opens/closes while clk is low and the rise lands on
                // the boundary edge itself.
                gate_d = (state_d == ST_RUN) && (act_n_d <= C_ONE);
            end

            always_ff @(posedge clk or negedge resetb) begin
                if (!resetb) begin
                    state_q <= ST_IDLE;
                    act_n_q <= C_DEF_N;
                    pend_q  <= '0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    tick_q  <= 1'b0;
                    hi_q    <= 1'b0;
                end else begin
                    state_q <= state_d;
                    act_n_q <= act_n_d;
                    pend_q  <= pend_d;
                    cnt_q   <= cnt_d;
                    busy_q  <= busy_d;
                    done_q  <= done_d;
                    tick_q  <= tick_d;
                    hi_q    <= hi_d;
                end
            end

            always_ff @(negedge clk or negedge resetb) begin
                if (!resetb) begin
                    hi_neg_q <= 1'b0;
                    gate_q   <= 1'b0;
                end else begin
                    hi_neg_q <= hi_q;
                    gate_q   <= gate_d;
                end
            end

            assign busy[gi]    = busy_q;
            assign tick[gi]    = tick_q;
            assign clk_out[gi] = hi_q | (act_n_q[0] & hi_neg_q) | (clk & gate_q);
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_clock_div_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_div_mc
// Brief    : Table-driven scoreboard bench for clock_div_mc (NCH=4, WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_div_mc;
    logic        clk = 1'b0;
    logic        resetb;
    logic [3:0]  en, load;
    logic [31:0] div_n;
    logic        sync_all;
    logic [3:0]  busy, tick, clk_out;

    clock_div_mc #(.NCH(4), .WIDTH(8), .DEF_N(2)) dut (
        .clk(clk), .resetb(resetb), .en(en), .div_n(div_n), .load(load),
        .sync_all(sync_all), .busy(busy), .tick(tick), .clk_out(clk_out)
    );

    always #5 clk = ~clk;

    // lo: clk_out in the low half of the cycle the row is driven in;
    // hi/tk/bz: clk_out, tick, busy just after the edge that samples the row.
    typedef struct {
        bit          rst;
        logic [3:0]  en;
        logic [3:0]  load;
        logic [31:0] div;
        logic        sync;
        logic [3:0]  lo, hi, tk, bz;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    function automatic void add(bit r, logic [3:0] e, logic [3:0] l, logic [31:0] d,
                                logic s, logic [3:0] lo, logic [3:0] hi,
                                logic [3:0] tk, logic [3:0] bz);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.div = d; v.sync = s;
        v.lo = lo; v.hi = hi; v.tk = tk; v.bz = bz;
        tbl.push_back(v);
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Entered and left at posedge+2; reset is asserted mid-cycle.
    task automatic do_reset();
        resetb = 1'b0; en = '0; load = '0; div_n = '0; sync_all = 1'b0;
        #1;
        chk("rst clk_out", 16'(clk_out), 16'd0);
        chk("rst tick", 16'(tick), 16'd0);
        chk("rst busy", 16'(busy), 16'd0);
        @(posedge clk); @(posedge clk); #2;
        resetb = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int nh, nl, nt;
        resetb = 1'b0; en = '0; load = '0; div_n = '0; sync_all = 1'b0;

        // A: default N=2, then load 5 with a second load ignored while busy
        add(1, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0001, 32'h5, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        add(0, 4'b0001, 4'b0001, 32'h3, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        // B: N=7 -> bypass N=1 -> N=4
        add(1, 4'b0000, 4'b0001, 32'h7, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        add(0, 4'b0001, 4'b0001, 32'h1, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        add(0, 4'b0001, 4'b0001, 32'h4, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        // C: N=3/4/6 on channels 0..2, sync_all mid-run
        add(1, 4'b0000, 4'b0111, 32'h00060403, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0111);
        add(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0111);
        add(0, 4'b0111, 4'b0000, 32'h0, 0, 4'b0000, 4'b0111, 4'b0111, 4'b0000);
        add(0, 4'b0111, 4'b0000, 32'h0, 0, 4'b0111, 4'b0111, 4'b0000, 4'b0000);
        add(0, 4'b0111, 4'b0000, 32'h0, 0, 4'b0110, 4'b0100, 4'b0000, 4'b0000);
        add(0, 4'b0111, 4'b0000, 32'h0, 1, 4'b0100, 4'b0111, 4'b0111, 4'b0000);
        add(0, 4'b0111, 4'b0000, 32'h0, 0, 4'b0111, 4'b0111, 4'b0000, 4'b0000);
        add(0, 4'b0111, 4'b0000, 32'h0, 0, 4'b0110, 4'b0100, 4'b0000, 4'b0000);
        add(0, 4'b0111, 4'b0000, 32'h0, 0, 4'b0100, 4'b0001, 4'b0001, 4'b0000);
        add(0, 4'b0111, 4'b0000, 32'h0, 0, 4'b0001, 4'b0011, 4'b0010, 4'b0000);
        add(0, 4'b0111, 4'b0000, 32'h0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        add(0, 4'b0111, 4'b0000, 32'h0, 0, 4'b0010, 4'b0101, 4'b0101, 4'b0000);
        // D: N=6, en dropped mid-high, stop, restart, then a cancelled stop
        add(1, 4'b0000, 4'b0001, 32'h6, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        add(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        // E: N=255 running high, async reset mid-period, restart at DEF_N
        add(1, 4'b0000, 4'b0001, 32'hFF, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(0, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        add(1, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

        @(posedge clk); #2;
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            vec_t e;
            v = tbl[i];
            if (v.rst) do_reset();
            en = v.en; load = v.load; div_n = v.div; sync_all = v.sync;
            sb.push_back(v);
            @(negedge clk); #1;
            chk($sformatf("row%0d clk_out_lo", i), 16'(clk_out), 16'(sb[0].lo));
            @(posedge clk); #1;
            e = sb.pop_front();
            chk($sformatf("row%0d clk_out_hi", i), 16'(clk_out), 16'(e.hi));
            chk($sformatf("row%0d tick", i), 16'(tick), 16'(e.tk));
            chk($sformatf("row%0d busy", i), 16'(busy), 16'(e.bz));
            #1;
        end

        // N=0 bypass on channel 3: clk_out follows clk from the start edge
        do_reset();
        load = 4'b1000; div_n = 32'h0;
        @(posedge clk); #2;
        load = 4'b0000;
        @(posedge clk); #2;
        en = 4'b1000;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("byp%0d clk_out_hi", k), 16'(clk_out), 16'b1000);
            chk($sformatf("byp%0d tick", k), 16'(tick), 16'b1000);
            @(negedge clk); #1;
            chk($sformatf("byp%0d clk_out_lo", k), 16'(clk_out), 16'd0);
        end
        @(posedge clk); #2;

        // N=255 exact: one full period measured on channel 1
        do_reset();
        load = 4'b0010; div_n = 32'h0000FF00;
        @(posedge clk); #2;
        load = 4'b0000;
        @(posedge clk); #2;
        en = 4'b0010;
        nh = 0; nl = 0; nt = 0;
        for (int k = 0; k < 255; k++) begin
            @(posedge clk); #1;
            if (clk_out[1]) nh++;
            if (tick[1]) nt++;
            @(negedge clk); #1;
            if (clk_out[1]) nl++;
        end
        chk("n255 high_posedge_samples", 16'(nh), 16'd128);
        chk("n255 high_negedge_samples", 16'(nl), 16'd127);
        chk("n255 ticks_in_period", 16'(nt), 16'd1);
        @(posedge clk); #1;
        chk("n255 next_tick", 16'(tick), 16'b0010);
        chk("n255 next_rise", 16'(clk_out), 16'b0010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
